// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / bus controller: FSM states,
// forward-select codes, stage write-enable bit positions and common patterns.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCESS_I = 3'd1,
        ST_ACCESS_D = 3'd2,
        ST_BOTH     = 3'd3,
        ST_GRANT    = 3'd4
    } ctrl_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // Bit positions inside stage_we = {PC, IF/ID, ID/EX, EX/M, M/WB}.
    localparam int WE_PC    = 4;
    localparam int WE_IF_ID = 3;
    localparam int WE_ID_EX = 2;
    localparam int WE_EX_M  = 1;
    localparam int WE_M_WB  = 0;

    localparam logic [4:0] WE_RUN         = 5'b11111;
    localparam logic [4:0] WE_STALL       = 5'b00000;
    localparam logic [4:0] WE_HOLD_FETCH  = 5'b00111;
    localparam logic [4:0] WE_HOLD_DECODE = 5'b00011;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_DMA = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_DMA-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_DMA-1:0] grant,
    output logic             valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        // First pass scans from ptr upward, second pass wraps to the low channels.
        for (int i = 0; i < N_DMA; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
        for (int i = 0; i < N_DMA; i++) begin
            if (!valid && req[i] && (i < int'(ptr))) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_bus_ctrl.sv
// Stall/forward controller for the 5-stage pipeline plus round-robin DMA bus
// arbitration with cycle stealing while both caches hit.
module pipe_hazard_bus_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W  = 2,
    parameter int N_DMA = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [RA_W-1:0]  rs,
    input  logic [RA_W-1:0]  rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic             halt_id,
    input  logic             load_ex,
    input  logic [RA_W-1:0]  dest_ex,
    input  logic [RA_W-1:0]  dest_m,
    input  logic [RA_W-1:0]  dest_wb,
    input  logic             reg_write_ex,
    input  logic             reg_write_m,
    input  logic             reg_write_wb,
    input  logic             i_cache_hit,
    input  logic             d_cache_hit,
    input  logic             i_ready,
    input  logic             d_ready,
    input  logic [N_DMA-1:0] BR,
    output logic [N_DMA-1:0] BG,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [4:0]       stage_we,
    output logic             flush_ex,
    output logic             both_access,
    output logic [2:0]       state_dbg
);

    localparam int PTR_W = (N_DMA > 1) ? $clog2(N_DMA) : 1;

    ctrl_state_e      state_q, state_d;
    logic [N_DMA-1:0] bg_q, bg_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_next, owner_idx;
    logic             i_seen_q, i_seen_d, d_seen_q, d_seen_d;
    logic [N_DMA-1:0] arb_grant;
    logic             arb_valid;
    logic             lu, owner_released;
    logic [4:0]       we;
    logic             flush;

    function automatic logic [1:0] fwd_sel(
        input logic            use_src,
        input logic [RA_W-1:0] src,
        input logic [RA_W-1:0] d_ex,  input logic w_ex,
        input logic [RA_W-1:0] d_m,   input logic w_m,
        input logic [RA_W-1:0] d_wb,  input logic w_wb
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_src) begin
            if (w_ex && src == d_ex)      sel = FWD_EX;
            else if (w_m && src == d_m)   sel = FWD_MEM;
            else if (w_wb && src == d_wb) sel = FWD_WB;
        end
        return sel;
    endfunction

    assign forward_a = fwd_sel(use_rs, rs, dest_ex, reg_write_ex, dest_m, reg_write_m,
                               dest_wb, reg_write_wb);
    assign forward_b = fwd_sel(use_rt, rt, dest_ex, reg_write_ex, dest_m, reg_write_m,
                               dest_wb, reg_write_wb);

    assign lu = load_ex && reg_write_ex &&
                ((use_rs && rs == dest_ex) || (use_rt && rt == dest_ex));

    rr_arbiter #(
        .N_DMA (N_DMA),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (BR),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Bus handshake: BR[k] is a level held for as long as channel k wants the bus;
    // BG[k] rises the cycle after the pick and stays high until BR[k] is seen low,
    // then drops on the next edge. Other requests are not considered meanwhile.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_DMA; i++) begin
            if (bg_q[i]) owner_idx = PTR_W'(i);
        end
    end

    assign ptr_next       = (owner_idx == PTR_W'(N_DMA - 1)) ? '0 : owner_idx + PTR_W'(1);
    assign owner_released = ~|(BR & bg_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            bg_q     <= '0;
            ptr_q    <= '0;
            i_seen_q <= 1'b0;
            d_seen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bg_q     <= bg_d;
            ptr_q    <= ptr_d;
            i_seen_q <= i_seen_d;
            d_seen_q <= d_seen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bg_d     = bg_q;
        ptr_d    = ptr_q;
        i_seen_d = i_seen_q;
        d_seen_d = d_seen_q;
        we       = WE_RUN;
        flush    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!d_cache_hit) begin
                    state_d = ST_ACCESS_D;
                    we      = WE_STALL;
                end else if (lu) begin
                    we    = WE_HOLD_DECODE;
                    flush = 1'b1;
                end else if (halt_id) begin
                    we = WE_HOLD_FETCH;
                end else if (!i_cache_hit) begin
                    state_d = ST_ACCESS_I;
                    we      = WE_HOLD_FETCH;
                    flush   = 1'b1;
                end else if (arb_valid) begin
                    state_d = ST_GRANT;
                    bg_d    = arb_grant;
                end
            end

            ST_ACCESS_I: begin
                if (!d_cache_hit) begin
                    state_d  = ST_BOTH;
                    we       = WE_STALL;
                    i_seen_d = i_ready;
                    d_seen_d = d_ready;
                end else if (i_ready) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end else begin
                    we    = WE_HOLD_FETCH;
                    flush = 1'b1;
                end
            end

            ST_ACCESS_D: begin
                if (!i_cache_hit) begin
                    state_d  = ST_BOTH;
                    we       = WE_STALL;
                    i_seen_d = i_ready;
                    d_seen_d = d_ready;
                end else if (d_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    we = WE_STALL;
                end
            end

            ST_BOTH: begin
                // Ready pulses may arrive in any order and only once each.
                if ((i_seen_q || i_ready) && (d_seen_q || d_ready)) begin
                    state_d  = ST_IDLE;
                    i_seen_d = 1'b0;
                    d_seen_d = 1'b0;
                end else begin
                    we       = WE_STALL;
                    i_seen_d = i_seen_q || i_ready;
                    d_seen_d = d_seen_q || d_ready;
                end
            end

            ST_GRANT: begin
                // Misses wait for the bus; the pipeline only steals cycles on hits.
                if (!d_cache_hit) begin
                    we = WE_STALL;
                end else if (!i_cache_hit) begin
                    we    = WE_HOLD_FETCH;
                    flush = 1'b1;
                end else if (lu) begin
                    we    = WE_HOLD_DECODE;
                    flush = 1'b1;
                end else if (halt_id) begin
                    we = WE_HOLD_FETCH;
                end
                if (owner_released) begin
                    state_d = ST_IDLE;
                    bg_d    = '0;
                    ptr_d   = ptr_next;
                end
            end

            default: begin
                state_d = ST_IDLE;
                bg_d    = '0;
            end
        endcase
    end

    assign stage_we    = reset_n ? we : WE_RUN;
    assign flush_ex    = reset_n && flush;
    assign BG          = bg_q;
    assign both_access = (state_q == ST_BOTH);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pipe_hazard_bus_ctrl.sv
// Scoreboarded bench for pipe_hazard_bus_ctrl: directed scenarios then random
// traffic, checked against a cycle-level reference model of the controller rules.
module tb_pipe_hazard_bus_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int RA_W  = 2;
    localparam int N_DMA = 3;
    localparam int EXP_W = N_DMA + 5 + 1 + 2 + 2 + 1;

    // Reference-model situations (the model's own vocabulary).
    localparam int M_IDLE = 0, M_FETCH_MISS = 1, M_DATA_MISS = 2, M_BOTH_MISS = 3, M_BUS = 4;

    logic             clk;
    logic             reset_n;
    logic [RA_W-1:0]  rs, rt, dest_ex, dest_m, dest_wb;
    logic             use_rs, use_rt, halt_id, load_ex;
    logic             reg_write_ex, reg_write_m, reg_write_wb;
    logic             i_cache_hit, d_cache_hit, i_ready, d_ready;
    logic [N_DMA-1:0] BR, BG;
    logic [1:0]       forward_a, forward_b;
    logic [4:0]       stage_we;
    logic             flush_ex, both_access;
    logic [2:0]       state_dbg;

    pipe_hazard_bus_ctrl #(.RA_W(RA_W), .N_DMA(N_DMA)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .halt_id(halt_id), .load_ex(load_ex),
        .dest_ex(dest_ex), .dest_m(dest_m), .dest_wb(dest_wb),
        .reg_write_ex(reg_write_ex), .reg_write_m(reg_write_m), .reg_write_wb(reg_write_wb),
        .i_cache_hit(i_cache_hit), .d_cache_hit(d_cache_hit),
        .i_ready(i_ready), .d_ready(d_ready),
        .BR(BR), .BG(BG),
        .forward_a(forward_a), .forward_b(forward_b),
        .stage_we(stage_we), .flush_ex(flush_ex),
        .both_access(both_access), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    string            dir_name[$];
    logic [7:0]       dir_act[$];
    logic [7:0]       dir_exp[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [EXP_W-1:0] mon_exp, mon_act;
    string            mon_name;
    logic [7:0]       mon_a, mon_e;

    // ---------------- reference model ----------------
    int m_mode, m_owner, m_ptr;
    bit m_iseen, m_dseen;

    function automatic logic [1:0] ref_fwd(logic use_src, logic [RA_W-1:0] src);
        if (use_src && reg_write_ex && src == dest_ex) return 2'd1;
        if (use_src && reg_write_m  && src == dest_m)  return 2'd2;
        if (use_src && reg_write_wb && src == dest_wb) return 2'd3;
        return 2'd0;
    endfunction

    function automatic bit chan_req(int ch);
        return ((BR >> ch) & N_DMA'(1)) != '0;
    endfunction

    // Computes the expected outputs for the inputs currently applied, queues them,
    // advances the model to the next cycle and waits one clock.
    task automatic tick();
        logic [N_DMA-1:0] bg_exp;
        logic [4:0]       we_exp;
        logic             fl_exp;
        bit               lu, dmiss, imiss, found;
        int               nxt, c;
        we_exp = 5'b11111;
        fl_exp = 1'b0;
        bg_exp = '0;
        if (!reset_n) begin
            m_mode = M_IDLE; m_owner = 0; m_ptr = 0; m_iseen = 0; m_dseen = 0;
        end else if (m_mode == M_BUS) begin
            bg_exp = N_DMA'(1) << m_owner;
        end
        nxt   = m_mode;
        dmiss = !d_cache_hit;
        imiss = !i_cache_hit;
        lu    = load_ex && reg_write_ex && ((use_rs && rs == dest_ex) || (use_rt && rt == dest_ex));
        if (reset_n) begin
            case (m_mode)
                M_IDLE: begin
                    if (dmiss) begin we_exp = 5'b00000; nxt = M_DATA_MISS; end
                    else if (lu) begin we_exp = 5'b00011; fl_exp = 1; end
                    else if (halt_id) we_exp = 5'b00111;
                    else if (imiss) begin we_exp = 5'b00111; fl_exp = 1; nxt = M_FETCH_MISS; end
                    else if (BR != '0) begin
                        found = 0;
                        for (int j = 0; j < N_DMA; j++) begin
                            c = (m_ptr + j) % N_DMA;
                            if (!found && chan_req(c)) begin m_owner = c; found = 1; end
                        end
                        nxt = M_BUS;
                    end
                end
                M_FETCH_MISS: begin
                    if (dmiss) begin
                        we_exp = 5'b00000; nxt = M_BOTH_MISS; m_iseen = i_ready; m_dseen = d_ready;
                    end else if (i_ready) begin fl_exp = 1; nxt = M_IDLE; end
                    else begin we_exp = 5'b00111; fl_exp = 1; end
                end
                M_DATA_MISS: begin
                    if (imiss) begin
                        we_exp = 5'b00000; nxt = M_BOTH_MISS; m_iseen = i_ready; m_dseen = d_ready;
                    end else if (d_ready) nxt = M_IDLE;
                    else we_exp = 5'b00000;
                end
                M_BOTH_MISS: begin
                    m_iseen = m_iseen || i_ready;
                    m_dseen = m_dseen || d_ready;
                    if (m_iseen && m_dseen) begin nxt = M_IDLE; m_iseen = 0; m_dseen = 0; end
                    else we_exp = 5'b00000;
                end
                default: begin
                    if (dmiss) we_exp = 5'b00000;
                    else if (imiss) begin we_exp = 5'b00111; fl_exp = 1; end
                    else if (lu) begin we_exp = 5'b00011; fl_exp = 1; end
                    else if (halt_id) we_exp = 5'b00111;
                    if (!chan_req(m_owner)) begin nxt = M_IDLE; m_ptr = (m_owner + 1) % N_DMA; end
                end
            endcase
        end
        exp_q.push_back({bg_exp, we_exp, fl_exp, ref_fwd(use_rs, rs), ref_fwd(use_rt, rt),
                         (m_mode == M_BOTH_MISS)});
        m_mode = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(string name, logic [7:0] act, logic [7:0] exp);
        dir_name.push_back(name);
        dir_act.push_back(act);
        dir_exp.push_back(exp);
    endtask

    task automatic set_defaults();
        rs = '0; rt = '0; dest_ex = '0; dest_m = '0; dest_wb = '0;
        use_rs = 0; use_rt = 0; halt_id = 0; load_ex = 0;
        reg_write_ex = 0; reg_write_m = 0; reg_write_wb = 0;
        i_cache_hit = 1; d_cache_hit = 1; i_ready = 0; d_ready = 0;
        BR = '0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        mon_act = {BG, stage_we, flush_ex, forward_a, forward_b, both_access};
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t actual=%b required=%b (bg,we,flush,fa,fb,both)",
                         $time, mon_act, mon_exp);
            end
        end
        while (dir_name.size() != 0) begin
            mon_name = dir_name.pop_front();
            mon_a    = dir_act.pop_front();
            mon_e    = dir_exp.pop_front();
            n_checks++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL %s t=%0t actual=%b required=%b", mon_name, $time, mon_a, mon_e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        set_defaults();
        reset_n = 1'b0;
        m_mode = M_IDLE; m_owner = 0; m_ptr = 0; m_iseen = 0; m_dseen = 0;
        @(posedge clk);
        #1;
        load_ex = 1; reg_write_ex = 1; use_rs = 1;
        #1;
        expect_now("reset_we", 8'(stage_we), 8'b11111);
        expect_now("reset_flush", 8'(flush_ex), 8'd0);
        expect_now("reset_bg", 8'(BG), 8'd0);
        tick();
        set_defaults();
        tick();
        reset_n = 1'b1;

        // Forwarding priority
        rs = 2; use_rs = 1; dest_ex = 2; reg_write_ex = 1; dest_m = 2; reg_write_m = 1;
        #1 expect_now("fwd_a_ex", 8'(forward_a), 8'd1);
        tick();
        reg_write_ex = 0;
        #1 expect_now("fwd_a_mem", 8'(forward_a), 8'd2);
        tick();
        set_defaults();

        // Load-use
        load_ex = 1; dest_ex = 1; reg_write_ex = 1; rt = 1; use_rt = 1;
        #1 expect_now("lu_we", 8'(stage_we), 8'b00011);
        expect_now("lu_flush", 8'(flush_ex), 8'd1);
        tick();
        load_ex = 0;
        #1 expect_now("lu_release_we", 8'(stage_we), 8'b11111);
        tick();
        set_defaults();

        // Staggered readies in BOTH
        i_cache_hit = 0;
        #1 expect_now("imiss_we", 8'(stage_we), 8'b00111);
        tick();
        tick();
        d_cache_hit = 0;
        tick();
        tick();
        i_ready = 1;
        tick();
        i_ready = 0;
        tick();
        #1 expect_now("both_hold_we", 8'(stage_we), 8'b00000);
        tick();
        d_ready = 1; i_cache_hit = 1; d_cache_hit = 1;
        #1 expect_now("both_exit_we", 8'(stage_we), 8'b11111);
        expect_now("both_exit_flag", 8'(both_access), 8'd1);
        tick();
        d_ready = 0;
        #1 expect_now("both_left", 8'(both_access), 8'd0);
        tick();

        // Round robin over BR=101, then cycle stealing
        BR = 3'b101;
        tick();
        #1 expect_now("rr_first_ch0", 8'(BG), 8'b001);
        BR = 3'b000;
        tick();
        #1 expect_now("rr_release", 8'(BG), 8'b000);
        BR = 3'b101;
        tick();
        #1 expect_now("rr_second_ch2", 8'(BG), 8'b100);
        BR = 3'b000;
        tick();
        BR = 3'b101;
        tick();
        #1 expect_now("rr_third_ch0", 8'(BG), 8'b001);
        BR = 3'b001;
        expect_now("steal_hit_we", 8'(stage_we), 8'b11111);
        tick();
        d_cache_hit = 0;
        #1 expect_now("steal_dmiss_we", 8'(stage_we), 8'b00000);
        expect_now("steal_dmiss_bg", 8'(BG), 8'b001);
        tick();
        BR = 3'b000;
        tick();
        #1 expect_now("post_grant_access_d", 8'(state_dbg), 8'(ST_IDLE));
        tick();
        d_ready = 1; d_cache_hit = 1;
        #1 expect_now("dready_resume_we", 8'(stage_we), 8'b11111);
        tick();
        d_ready = 0;
        tick();

        // Asynchronous reset during a grant
        BR = 3'b010;
        tick();
        #1 expect_now("grant_before_reset", 8'(BG), 8'b010);
        reset_n = 1'b0;
        #1 expect_now("async_reset_bg", 8'(BG), 8'd0);
        expect_now("async_reset_state", 8'(state_dbg), 8'(ST_IDLE));
        expect_now("async_reset_we", 8'(stage_we), 8'b11111);
        @(posedge clk);
        #1;
        tick();
        reset_n = 1'b1;
        BR = '0;
        tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rs           = RA_W'($urandom_range(0, 3));
            rt           = RA_W'($urandom_range(0, 3));
            dest_ex      = RA_W'($urandom_range(0, 3));
            dest_m       = RA_W'($urandom_range(0, 3));
            dest_wb      = RA_W'($urandom_range(0, 3));
            use_rs       = ($urandom_range(0, 1) == 1);
            use_rt       = ($urandom_range(0, 1) == 1);
            reg_write_ex = ($urandom_range(0, 1) == 1);
            reg_write_m  = ($urandom_range(0, 1) == 1);
            reg_write_wb = ($urandom_range(0, 1) == 1);
            load_ex      = ($urandom_range(0, 3) == 0);
            halt_id      = ($urandom_range(0, 15) == 0);
            i_cache_hit  = ($urandom_range(0, 5) != 0);
            d_cache_hit  = ($urandom_range(0, 5) != 0);
            i_ready      = ($urandom_range(0, 3) == 0);
            d_ready      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) BR = N_DMA'($urandom_range(0, 7));
            tick();
        end

        set_defaults();
        tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
